// File: rtl/matmul_seq.sv
// matmul_seq: sequential N x N unsigned matrix multiplier.
// One multiply-accumulate unit walks the N^3 partial products of R = A x B.
// Operands are captured when a trigger is accepted in IDLE. Results collect in
// an internal buffer, and that buffer is copied to o_result in one step, so
// o_result only ever shows complete products.
//
// Handshake: o_ready is high only in IDLE. A start is accepted on a rising edge
// where i_trigger=1 and o_ready=1. o_valid is high for exactly one cycle, the
// cycle in which o_result first shows the new product. i_trigger is ignored
// while o_ready=0.
module matmul_seq #(
    parameter int N        = 3,
    parameter int DW       = 7,
    parameter int OW       = 7,
    parameter int SATURATE = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_trigger,
    input  logic [N*N*DW-1:0]   i_a,
    input  logic [N*N*DW-1:0]   i_b,
    output logic                o_ready,
    output logic                o_valid,
    output logic [N*N*OW-1:0]   o_result
);

    // The accumulator holds a full dot product, so it can never overflow.
    localparam int AW = 2 * DW + $clog2(N);
    localparam int IW = ($clog2(N) > 0) ? $clog2(N) : 1;
    // This width holds both the sum and the output maximum without loss.
    localparam int SW = (AW > OW) ? AW : OW;
    localparam logic [IW-1:0] LAST    = IW'(N - 1);
    localparam logic [SW-1:0] OUT_MAX = SW'({OW{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N*N*DW-1:0]   a_q, a_d;
    logic [N*N*DW-1:0]   b_q, b_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [IW-1:0]       row_q, row_d;
    logic [IW-1:0]       col_q, col_d;
    logic [IW-1:0]       k_q, k_d;
    logic [N*N*OW-1:0]   buf_q, buf_d;
    logic [N*N*OW-1:0]   result_q, result_d;
    logic                valid_q, valid_d;

    logic [DW-1:0]       a_elem;
    logic [DW-1:0]       b_elem;
    logic [2*DW-1:0]     prod;
    logic [AW-1:0]       sum;
    logic [SW-1:0]       sum_ext;
    logic [OW-1:0]       red;

    // MAC datapath: select A[row][k] and B[k][col], then multiply, add and reduce.
    always_comb begin
        a_elem  = a_q[(int'(row_q) * N + int'(k_q)) * DW +: DW];
        b_elem  = b_q[(int'(k_q) * N + int'(col_q)) * DW +: DW];
        prod    = (2*DW)'(a_elem) * (2*DW)'(b_elem);
        sum     = acc_q + AW'(prod);
        sum_ext = SW'(sum);
        if ((SATURATE != 0) && (sum_ext > OUT_MAX)) begin
            red = {OW{1'b1}};
        end else begin
            red = sum_ext[OW-1:0];
        end
    end

    // Next-state logic: capture the operands, run the index walk, publish the result.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        buf_d    = buf_q;
        result_d = result_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_trigger) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    acc_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (k_q != LAST) begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end else begin
                    // The last term of this dot product is summed here without
                    // passing through acc.
                    buf_d[(int'(row_q) * N + int'(col_q)) * OW +: OW] = red;
                    acc_d = '0;
                    k_d   = '0;
                    if (col_q == LAST) begin
                        col_d = '0;
                        if (row_q == LAST) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                result_d = buf_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. A synchronous reset aborts any job in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            buf_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed testbench for matmul_seq. It uses three instances:
//   dut0: N=3 DW=7 OW=7 in wrap mode
//   dut1: N=3 DW=7 OW=7 in saturate mode
//   dut2: N=2 DW=8 OW=16
// Edge e is the e-th rising edge after a job starts. Outputs are sampled 1 ns after that edge.
module tb_matmul_seq;

  logic clk;
  logic rst;

  logic        trig0, trig1, trig2;
  logic [62:0] a0, b0, a1, b1;
  logic [31:0] a2, b2;
  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [62:0] res0, res1;
  logic [63:0] res2;

  int pass_cnt = 0;
  int total_cnt = 0;

  int id9[9]   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int seq9[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int all127[9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
  int all3[9]  = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
  int zero9[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ma2[4]   = '{1, 2, 3, 4};
  int mb2[4]   = '{5, 6, 7, 8};
  int mr2[4]   = '{19, 22, 43, 50};

  matmul_seq #(.N(3), .DW(7), .OW(7), .SATURATE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_trigger(trig0), .i_a(a0), .i_b(b0),
    .o_ready(rdy0), .o_valid(vld0), .o_result(res0)
  );

  matmul_seq #(.N(3), .DW(7), .OW(7), .SATURATE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_trigger(trig1), .i_a(a1), .i_b(b1),
    .o_ready(rdy1), .o_valid(vld1), .o_result(res1)
  );

  matmul_seq #(.N(2), .DW(8), .OW(16), .SATURATE(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_trigger(trig2), .i_a(a2), .i_b(b2),
    .o_ready(rdy2), .o_valid(vld2), .o_result(res2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [62:0] pk7(input int v[9]);
    logic [62:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*7 +: 7] = 7'(v[i]);
    return r;
  endfunction

  function automatic logic [31:0] pk8(input int v[4]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(v[i]);
    return r;
  endfunction

  function automatic logic [63:0] pk16(input int v[4]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(v[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int n_pulse;
  int pulse_e[4];
  int ready_low_bad;

  initial begin
    rst = 1'b1;
    trig0 = 0; trig1 = 0; trig2 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_ready", rdy0, 1);
    check("reset_valid", vld0, 0);
    check("reset_result", res0, 0);
    check("reset_ready_n2", rdy2, 1);

    // Identity job: A=I, B=1..9
    a0 = pk7(id9); b0 = pk7(seq9); trig0 = 1;
    tick();                                   // edge 0: accept
    trig0 = 0;
    a0 = pk7(zero9); b0 = pk7(zero9);         // the inputs were captured at edge 0
    check("id_ready_after_accept", rdy0, 0);
    ready_low_bad = 0;
    n_pulse = 0;
    for (int e = 1; e <= 27; e++) begin
      tick();
      if (rdy0 !== 1'b0) ready_low_bad++;
      if (vld0 !== 1'b0) n_pulse++;
    end
    check("id_ready_low_1_27", ready_low_bad, 0);
    check("id_no_early_valid", n_pulse, 0);
    tick();                                   // edge 28
    check("id_valid_e28", vld0, 1);
    check("id_result", res0, pk7(seq9));
    check("id_ready_e28", rdy0, 1);
    tick();
    check("id_valid_drop", vld0, 0);
    check("id_result_hold", res0, pk7(seq9));

    // Overflow: all 127, wrap mode (dut0) and saturate mode (dut1)
    a0 = pk7(all127); b0 = pk7(all127); trig0 = 1;
    a1 = pk7(all127); b1 = pk7(all127); trig1 = 1;
    tick();
    trig0 = 0; trig1 = 0;
    for (int e = 1; e <= 27; e++) tick();
    tick();
    check("ovf_wrap_valid", vld0, 1);
    check("ovf_wrap_result", res0, pk7(all3));
    check("ovf_sat_valid", vld1, 1);
    check("ovf_sat_result", res1, pk7(all127));
    tick();

    // Busy trigger: a second trigger at edge 5 must be ignored
    a0 = pk7(id9); b0 = pk7(seq9); trig0 = 1;
    tick();                                   // edge 0
    trig0 = 0;
    n_pulse = 0;
    pulse_e[0] = -1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) begin
        a0 = pk7(all127); b0 = pk7(all127); trig0 = 1;
      end
      tick();
      if (e == 5) trig0 = 0;
      if (vld0 === 1'b1) begin
        if (n_pulse < 4) pulse_e[n_pulse] = e;
        n_pulse++;
      end
    end
    check("busy_one_pulse", n_pulse, 1);
    check("busy_pulse_edge", pulse_e[0], 28);
    check("busy_result", res0, pk7(seq9));

    // Reset in the middle of a job at edge 10
    a0 = pk7(all127); b0 = pk7(all127); trig0 = 1;
    tick();                                   // edge 0
    trig0 = 0;
    for (int e = 1; e <= 9; e++) tick();
    rst = 1;
    tick();                                   // edge 10: abort
    rst = 0;
    check("midrst_ready", rdy0, 1);
    check("midrst_valid", vld0, 0);
    check("midrst_result", res0, 0);
    n_pulse = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (vld0 === 1'b1) n_pulse++;
    end
    check("midrst_no_pulse", n_pulse, 0);
    // Reset together with a trigger: reset wins
    a0 = pk7(id9); b0 = pk7(seq9); trig0 = 1; rst = 1;
    tick();
    rst = 0; trig0 = 0;
    check("rst_beats_trig", rdy0, 1);
    // A new job completes normally after the abort
    trig0 = 1;
    tick();                                   // edge 0
    trig0 = 0;
    n_pulse = 0;
    pulse_e[0] = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (vld0 === 1'b1) begin
        if (n_pulse < 4) pulse_e[n_pulse] = e;
        n_pulse++;
      end
      if (e == 28) check("fresh_result", res0, pk7(seq9));
    end
    check("fresh_one_pulse", n_pulse, 1);
    check("fresh_pulse_edge", pulse_e[0], 28);

    // N=2, DW=8, OW=16
    a2 = pk8(ma2); b2 = pk8(mb2); trig2 = 1;
    tick();                                   // edge 0
    trig2 = 0;
    n_pulse = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (vld2 === 1'b1) n_pulse++;
    end
    check("n2_no_early_valid", n_pulse, 0);
    tick();                                   // edge 9
    check("n2_valid_e9", vld2, 1);
    check("n2_result", res2, pk16(mr2));
    check("n2_ready_e9", rdy2, 1);

    // Back-to-back with the trigger held high
    a0 = pk7(id9); b0 = pk7(seq9); trig0 = 1;
    n_pulse = 0;
    pulse_e[0] = -1; pulse_e[1] = -1;
    ready_low_bad = 0;
    for (int e = 0; e <= 60; e++) begin
      tick();
      if (e == 29 && rdy0 !== 1'b0) ready_low_bad++;  // accepted again at edge 29
      if (e == 29 && vld0 !== 1'b0) ready_low_bad++;  // o_valid drops at that accept
      if (vld0 === 1'b1) begin
        if (n_pulse < 4) pulse_e[n_pulse] = e;
        n_pulse++;
      end
    end
    trig0 = 0;
    check("b2b_pulse_count", n_pulse, 2);
    check("b2b_pulse0_edge", pulse_e[0], 28);
    check("b2b_pulse1_edge", pulse_e[1], 57);
    check("b2b_reaccept_e29", ready_low_bad, 0);
    check("b2b_result", res0, pk7(seq9));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
